// File: rtl/windowed_pulse_counter.sv
// Counts per-channel events (edges or high cycles) of asynchronous inputs over a
// programmable window of clk_in cycles, single-shot or back-to-back continuous.

module windowed_pulse_counter #(
    parameter int CHANNELS     = 4,
    parameter int COUNT_WIDTH  = 32,
    parameter int WINDOW_WIDTH = 32
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [CHANNELS-1:0]             signal_in,
    input  logic [1:0]                      mode_in,
    input  logic [WINDOW_WIDTH-1:0]         window_in,
    input  logic                            continuous_in,
    input  logic                            start_in,
    input  logic                            abort_in,
    output logic                            busy_out,
    output logic [CHANNELS*COUNT_WIDTH-1:0] tally_out,
    output logic                            valid_out,
    output logic [CHANNELS-1:0]             overflow_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_HIGH = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                               r_state;
    state_t                               w_next_state;
    mode_t                                r_mode;
    logic                                 r_continuous;
    logic [WINDOW_WIDTH-1:0]              r_window;
    logic [WINDOW_WIDTH-1:0]              r_cycle;
    logic [CHANNELS-1:0]                  r_sync1;
    logic [CHANNELS-1:0]                  r_sync2;
    logic [CHANNELS-1:0]                  r_prev;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0] r_acc;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0] w_acc_next;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0] r_tally;
    logic [CHANNELS-1:0]                  r_ovf;
    logic [CHANNELS-1:0]                  w_ovf_next;
    logic [CHANNELS-1:0]                  r_ovf_out;
    logic [CHANNELS-1:0]                  w_event;
    logic                                 r_valid;
    logic                                 w_start_ok;
    logic                                 w_last_cycle;

    assign w_start_ok   = start_in && (window_in != '0);
    assign w_last_cycle = (r_cycle == r_window - WINDOW_WIDTH'(1));

    // NOTE: sequential state uses <= so each stage samples the pre-edge value of the stage before it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= signal_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_event = '0;
        case (r_mode)
            MODE_RISE: w_event = r_sync2 & ~r_prev;
            MODE_FALL: w_event = ~r_sync2 & r_prev;
            MODE_HIGH: w_event = r_sync2;
            MODE_BOTH: w_event = r_sync2 ^ r_prev;
            default:   w_event = '0;
        endcase
    end

    // A saturated channel holds its count and records the lost event as overflow.
    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_event[k]) begin
                if (r_acc[k] == COUNT_MAX) begin
                    w_ovf_next[k] = 1'b1;
                end else begin
                    w_acc_next[k] = r_acc[k] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_in) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_cycle && !r_continuous) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the accumulators are plain flops, not RAM, so they are reset like any other register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mode       <= MODE_RISE;
            r_continuous <= 1'b0;
            r_window     <= '0;
            r_cycle      <= '0;
            r_acc        <= '0;
            r_ovf        <= '0;
            r_tally      <= '0;
            r_ovf_out    <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_mode       <= mode_t'(mode_in);
                        r_continuous <= continuous_in;
                        r_window     <= window_in;
                        r_cycle      <= '0;
                        r_acc        <= '0;
                        r_ovf        <= '0;
                    end
                end
                ST_RUN: begin
                    // Abort wins over completion: no publish, outputs keep the last window.
                    if (!abort_in) begin
                        if (w_last_cycle) begin
                            r_tally   <= w_acc_next;
                            r_ovf_out <= w_ovf_next;
                            r_valid   <= 1'b1;
                            r_acc     <= '0;
                            r_ovf     <= '0;
                            r_cycle   <= '0;
                        end else begin
                            r_acc   <= w_acc_next;
                            r_ovf   <= w_ovf_next;
                            r_cycle <= r_cycle + WINDOW_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out     = (r_state == ST_RUN);
    assign tally_out    = r_tally;
    assign valid_out    = r_valid;
    assign overflow_out = r_ovf_out;

endmodule

// File: tb/tb_windowed_pulse_counter.sv
// Directed bench for windowed_pulse_counter: a window-level model derived from the
// input history is compared every cycle, plus hand-computed expectations per scenario.

module tb_windowed_pulse_counter;

    localparam int CH = 2;
    localparam int CW = 8;
    localparam int WW = 16;
    localparam int HIST_DEPTH = 16384;

    logic               clk;
    logic               rst;
    logic [CH-1:0]      sig;
    logic [1:0]         mode;
    logic [WW-1:0]      win;
    logic               cont;
    logic               start;
    logic               abort;
    logic               busy_out;
    logic [CH*CW-1:0]   tally_out;
    logic               valid_out;
    logic [CH-1:0]      overflow_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nsteps   = 0;
    bit tog      = 1'b0;

    windowed_pulse_counter #(
        .CHANNELS    (CH),
        .COUNT_WIDTH (CW),
        .WINDOW_WIDTH(WW)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .signal_in    (sig),
        .mode_in      (mode),
        .window_in    (win),
        .continuous_in(cont),
        .start_in     (start),
        .abort_in     (abort),
        .busy_out     (busy_out),
        .tally_out    (tally_out),
        .valid_out    (valid_out),
        .overflow_out (overflow_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #150000;
        $display("FAIL watchdog: got no end of test, expected completion within 15000 cycles");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- window-level reference model ----------------
    // The value the DUT sees as "current" on edge k is the input sampled two edges earlier.
    logic [CH-1:0] hist [HIST_DEPTH];
    bit            m_run = 1'b0;
    int            m_first;
    int            m_len;
    logic [1:0]    m_mode;
    bit            m_cont;
    logic          e_busy = 1'b0;
    logic          e_valid = 1'b0;
    logic [CW-1:0] e_tally [CH];
    logic [CH-1:0] e_ovf = '0;

    function automatic logic [CH-1:0] h(input int k);
        if (k < 0 || k >= HIST_DEPTH) return '0;
        return hist[k];
    endfunction

    function automatic bit ev(input logic [1:0] m, input logic cur, input logic prv);
        case (m)
            2'b00:   return cur && !prv;
            2'b01:   return !cur && prv;
            2'b10:   return cur;
            default: return cur != prv;
        endcase
    endfunction

    task automatic close_window(input int last);
        logic [CH-1:0] a;
        logic [CH-1:0] b;
        int cnt;
        for (int c = 0; c < CH; c++) begin
            cnt = 0;
            for (int k = m_first; k <= last; k++) begin
                a = h(k - 2);
                b = h(k - 3);
                if (ev(m_mode, a[c], b[c])) cnt++;
            end
            e_tally[c] = (cnt > 255) ? 8'd255 : 8'(cnt);
            e_ovf[c]   = (cnt > 255);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_run   = 1'b0;
            e_valid = 1'b0;
            for (int c = 0; c < CH; c++) e_tally[c] = '0;
            e_ovf = '0;
            if (cyc < HIST_DEPTH) hist[cyc] = '0;
        end else begin
            if (cyc < HIST_DEPTH) hist[cyc] = sig;
            e_valid = 1'b0;
            if (!m_run) begin
                if (start && win != '0) begin
                    m_run   = 1'b1;
                    m_first = cyc + 1;
                    m_len   = int'(win);
                    m_mode  = mode;
                    m_cont  = cont;
                end
            end else if (abort) begin
                m_run = 1'b0;
            end else if (cyc == m_first + m_len - 1) begin
                close_window(cyc);
                e_valid = 1'b1;
                if (m_cont) m_first = cyc + 1;
                else        m_run   = 1'b0;
            end
        end
        e_busy = m_run;
        cyc++;
        #1;
        check("cyc_busy",     32'(busy_out),           32'(e_busy));
        check("cyc_valid",    32'(valid_out),          32'(e_valid));
        check("cyc_tally0",   32'(tally_out[0 +: CW]), 32'(e_tally[0]));
        check("cyc_tally1",   32'(tally_out[CW +: CW]), 32'(e_tally[1]));
        check("cyc_overflow", 32'(overflow_out),       32'(e_ovf));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        nsteps++;
        if (tog) sig[0] = ~sig[0];
    endtask

    // Start is presented for one edge, then the settings are scrambled to prove they are latched.
    task automatic start_win(input int w, input logic [1:0] m, input bit c);
        step();
        start = 1'b1;
        win   = WW'(w);
        mode  = m;
        cont  = c;
        step();
        start = 1'b0;
        win   = WW'(w + 7);
        mode  = ~m;
        cont  = ~c;
    endtask

    task automatic wait_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (valid_out === 1'b1) seen = 1'b1;
        end
    endtask

    function automatic logic [31:0] tal(input int c);
        return 32'(tally_out[c*CW +: CW]);
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        bit seen;
        int t0;
        int prev_t;
        int sum;

        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
        mode = 2'b00; win = '0; sig = '0;
        repeat (5) step();
        check("reset_busy",     32'(busy_out),     0);
        check("reset_valid",    32'(valid_out),    0);
        check("reset_tally0",   tal(0),            0);
        check("reset_tally1",   tal(1),            0);
        check("reset_overflow", 32'(overflow_out), 0);
        rst = 1'b0;
        repeat (2) step();

        // Ten 2-high/3-low pulses on ch0 inside a 100-cycle rising-edge window.
        start_win(100, 2'b00, 1'b0);
        for (int p = 0; p < 10; p++) begin
            sig[0] = 1'b1; step(); step();
            sig[0] = 1'b0; step(); step(); step();
        end
        wait_valid(100, seen);
        check("s1_valid_seen", 32'(seen), 1);
        check("s1_tally0",     tal(0), 10);
        check("s1_tally1",     tal(1), 0);
        check("s1_overflow",   32'(overflow_out), 0);
        check("s1_busy_low",   32'(busy_out), 0);
        check("s1_model_pin",  32'(e_tally[0]), 10);
        step();
        check("s1_valid_one_cycle", 32'(valid_out), 0);

        // High-cycle mode: ch0 high all window, ch1 high for the first 19 counted cycles.
        sig = 2'b11;
        repeat (3) step();
        start_win(50, 2'b10, 1'b0);
        repeat (17) step();
        sig[1] = 1'b0;
        wait_valid(80, seen);
        check("s2_valid_seen", 32'(seen), 1);
        check("s2_tally0",     tal(0), 50);
        check("s2_tally1",     tal(1), 19);
        check("s2_model_pin",  32'(e_tally[1]), 19);
        sig = 2'b00;

        // Both-edges mode with ch0 toggling every cycle; ch1 held steady high.
        sig[1] = 1'b1;
        tog = 1'b1;
        repeat (3) step();
        start_win(20, 2'b11, 1'b0);
        wait_valid(40, seen);
        check("s3_valid_seen", 32'(seen), 1);
        check("s3_tally0",     tal(0), 20);
        check("s3_tally1",     tal(1), 0);
        tog = 1'b0;
        sig = 2'b00;

        // Saturation: 300 high cycles into an 8-bit tally.
        sig[0] = 1'b1;
        repeat (3) step();
        start_win(300, 2'b10, 1'b0);
        wait_valid(320, seen);
        check("s4_valid_seen", 32'(seen), 1);
        check("s4_tally0",     tal(0), 255);
        check("s4_overflow",   32'(overflow_out), 32'b01);
        check("s4_model_pin",  32'(e_ovf), 32'b01);
        sig[0] = 1'b0;

        // Continuous rising-edge windows of 20 with ch0 toggling every cycle.
        tog = 1'b1;
        repeat (3) step();
        start_win(20, 2'b00, 1'b1);
        sum = 0;
        prev_t = 0;
        for (int w = 0; w < 5; w++) begin
            wait_valid(30, seen);
            check("s5_valid_seen", 32'(seen), 1);
            check("s5_tally0",     tal(0), 10);
            check("s5_busy_held",  32'(busy_out), 1);
            if (w > 0) check("s5_period", 32'(nsteps - prev_t), 20);
            prev_t = nsteps;
            sum += int'(tal(0));
        end
        check("s5_sum", 32'(sum), 50);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("s5_abort_idle", 32'(busy_out), 0);

        // Abort at RUN cycle 30: no result, previous tally of 10 kept.
        start_win(100, 2'b00, 1'b0);
        repeat (29) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("s6_abort_busy",  32'(busy_out), 0);
        check("s6_abort_valid", 32'(valid_out), 0);
        check("s6_abort_tally", tal(0), 10);
        wait_valid(110, seen);
        check("s6_no_valid", 32'(seen), 0);

        // Reset at RUN cycle 30 clears everything on the next cycle.
        start_win(100, 2'b00, 1'b0);
        repeat (29) step();
        rst = 1'b1;
        step();
        check("s6_rst_busy",     32'(busy_out), 0);
        check("s6_rst_valid",    32'(valid_out), 0);
        check("s6_rst_tally0",   tal(0), 0);
        check("s6_rst_tally1",   tal(1), 0);
        check("s6_rst_overflow", 32'(overflow_out), 0);

        // Input already high across reset counts as a single rising edge.
        tog = 1'b0;
        sig = 2'b01;
        repeat (3) step();
        rst   = 1'b0;
        start = 1'b1;
        win   = WW'(10);
        mode  = 2'b00;
        cont  = 1'b0;
        step();
        start = 1'b0;
        wait_valid(20, seen);
        check("s6_high_at_reset_seen",  32'(seen), 1);
        check("s6_high_at_reset_tally", tal(0), 1);

        // Zero-length start and idle abort are ignored; restart during RUN is ignored.
        sig = 2'b00;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("s7_idle_abort", 32'(busy_out), 0);
        start = 1'b1;
        win   = '0;
        mode  = 2'b00;
        step();
        start = 1'b0;
        step();
        check("s7_zero_window", 32'(busy_out), 0);
        tog = 1'b1;
        repeat (3) step();
        start_win(30, 2'b00, 1'b0);
        t0 = nsteps;
        repeat (10) step();
        start = 1'b1;
        win   = WW'(60);
        step();
        start = 1'b0;
        wait_valid(60, seen);
        check("s7_valid_seen",  32'(seen), 1);
        check("s7_window_len",  32'(nsteps - t0), 30);
        check("s7_tally0",      tal(0), 15);
        check("s7_busy_low",    32'(busy_out), 0);
        tog = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
